// File: rtl/wr_fec_dummy_pck_chk.sv
// Purpose : checks dummy test frames on a 16-bit pipelined fabric sink and keeps
//           frame/length/payload/sequence statistics behind a Wishbone slave.
// Latency : snk_ack_o and wb_ack_o one cycle after the request; frame_ok_p_o one
//           cycle after the end-of-frame (DONE) cycle.
// Backpr. : snk_stall_o is raised only for the single DONE cycle after each frame;
//           all other beats are accepted and acked unconditionally.
// Ports   : clk_sys/rst_n (async, active-high); snk_* fabric sink (adr 0 = data,
//           others acked and ignored); wb_* register slave (8 words); frame_ok_p_o.
module wr_fec_dummy_pck_chk #(
  parameter int g_hdr_words = 7,
  parameter int g_cnt_width = 16
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  input  logic [15:0]            snk_dat_i,
  input  logic [1:0]             snk_adr_i,
  input  logic [1:0]             snk_sel_i,
  input  logic                   snk_cyc_i,
  input  logic                   snk_stb_i,
  input  logic                   snk_we_i,
  output logic                   snk_stall_o,
  output logic                   snk_ack_o,
  output logic                   snk_err_o,
  input  logic [2:0]             wb_adr_i,
  input  logic [31:0]            wb_dat_i,
  output logic [31:0]            wb_dat_o,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  output logic                   wb_ack_o,
  output logic                   frame_ok_p_o
);

  localparam int HCW = $clog2(g_hdr_words + 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_PAYLOAD, S_DONE} state_t;

  state_t                 state;
  logic                   cyc_d;
  logic                   rise_pend;
  logic [HCW-1:0]         hdr_cnt;
  logic [15:0]            len;
  logic [15:0]            seq;
  logic [15:0]            exp_word;
  logic                   pay_err;
  logic                   reached;

  logic                   en;
  logic [15:0]            exp_len;
  logic [g_cnt_width-1:0] rx_cnt, len_err_cnt, pay_err_cnt, seq_err_cnt;
  logic [15:0]            last_seq;
  logic                   seq_valid;

  logic        beat, data_beat, half, word_ok;
  logic [16:0] len_sum;
  logic [15:0] len_nxt;
  logic        wb_req, clr;
  logic        f_len_err, f_seq_err;
  logic [31:0] rd_mux;
  logic        unused_wb_bits;

  function automatic logic [g_cnt_width-1:0] sat_inc(input logic [g_cnt_width-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign snk_stall_o = (state == S_DONE);
  assign snk_err_o   = 1'b0;
  assign beat        = snk_cyc_i & snk_stb_i & snk_we_i & ~snk_stall_o;
  assign data_beat   = beat & (snk_adr_i == 2'd0);
  assign half        = (snk_sel_i == 2'b10);
  assign len_sum     = {1'b0, len} + (half ? 17'd1 : 17'd2);
  assign len_nxt     = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  // A half beat carries only the high byte, so the low byte is never compared.
  assign word_ok     = half ? (snk_dat_i[15:8] == exp_word[15:8]) : (snk_dat_i == exp_word);

  assign wb_req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign clr         = wb_req & wb_we_i & (wb_adr_i == 3'd0) & wb_dat_i[1];
  assign unused_wb_bits = ^wb_dat_i[31:16];

  // Frames that never reached the payload are always too short.
  assign f_len_err = ~reached | (len != exp_len);
  assign f_seq_err = reached & seq_valid & (seq != last_seq + 16'd1);

  always_ff @(posedge clk_sys or posedge rst_n) begin
    if (rst_n) begin
      snk_ack_o <= 1'b0;
      state     <= S_IDLE;
      // Treat cyc as already high so a frame in progress at release is skipped.
      cyc_d     <= 1'b1;
      rise_pend <= 1'b0;
      hdr_cnt   <= '0;
      len       <= '0;
      seq       <= '0;
      exp_word  <= '0;
      pay_err   <= 1'b0;
      reached   <= 1'b0;
    end else begin
      snk_ack_o <= beat;
      cyc_d     <= snk_cyc_i;
      case (state)
        S_IDLE: begin
          rise_pend <= 1'b0;
          // rise_pend covers a cyc edge that arrived while stalled in DONE.
          if (snk_cyc_i && (!cyc_d || rise_pend)) begin
            len     <= data_beat ? (half ? 16'd1 : 16'd2) : 16'd0;
            hdr_cnt <= data_beat ? HCW'(1) : HCW'(0);
            pay_err <= 1'b0;
            reached <= 1'b0;
            if (data_beat && g_hdr_words == 1) state <= S_SEQ;
            else                               state <= S_HDR;
          end
        end
        S_HDR: begin
          if (!snk_cyc_i) state <= S_DONE;
          else if (data_beat) begin
            len     <= len_nxt;
            hdr_cnt <= hdr_cnt + 1'b1;
            if (hdr_cnt == HCW'(g_hdr_words - 1)) state <= S_SEQ;
          end
        end
        S_SEQ: begin
          if (!snk_cyc_i) state <= S_DONE;
          else if (data_beat) begin
            len      <= len_nxt;
            seq      <= snk_dat_i;
            exp_word <= snk_dat_i + 16'd1;
            reached  <= 1'b1;
            state    <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!snk_cyc_i) state <= S_DONE;
          else if (data_beat) begin
            len      <= len_nxt;
            exp_word <= exp_word + 16'd1;
            if (!word_ok) pay_err <= 1'b1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          rise_pend <= snk_cyc_i & ~cyc_d;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Statistics; a clear in the DONE cycle wins over that frame's update.
  always_ff @(posedge clk_sys or posedge rst_n) begin
    if (rst_n) begin
      rx_cnt       <= '0;
      len_err_cnt  <= '0;
      pay_err_cnt  <= '0;
      seq_err_cnt  <= '0;
      last_seq     <= '0;
      seq_valid    <= 1'b0;
      frame_ok_p_o <= 1'b0;
    end else begin
      frame_ok_p_o <= 1'b0;
      if (clr) begin
        rx_cnt      <= '0;
        len_err_cnt <= '0;
        pay_err_cnt <= '0;
        seq_err_cnt <= '0;
        last_seq    <= '0;
        seq_valid   <= 1'b0;
      end else if (state == S_DONE && en) begin
        rx_cnt <= sat_inc(rx_cnt);
        if (f_len_err) len_err_cnt <= sat_inc(len_err_cnt);
        if (pay_err)   pay_err_cnt <= sat_inc(pay_err_cnt);
        if (f_seq_err) seq_err_cnt <= sat_inc(seq_err_cnt);
        if (reached) begin
          last_seq  <= seq;
          seq_valid <= 1'b1;
        end
        frame_ok_p_o <= ~(f_len_err | pay_err | f_seq_err);
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (wb_adr_i)
      3'd0: rd_mux[0]                 = en;
      3'd1: rd_mux[15:0]              = exp_len;
      3'd2: rd_mux[g_cnt_width-1:0]   = rx_cnt;
      3'd3: rd_mux[g_cnt_width-1:0]   = len_err_cnt;
      3'd4: rd_mux[g_cnt_width-1:0]   = pay_err_cnt;
      3'd5: rd_mux[g_cnt_width-1:0]   = seq_err_cnt;
      3'd6: begin
        rd_mux[15:0] = last_seq;
        rd_mux[16]   = seq_valid;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst_n) begin
    if (rst_n) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      en       <= 1'b0;
      exp_len  <= '0;
    end else begin
      wb_ack_o <= wb_req;
      wb_dat_o <= wb_req ? rd_mux : 32'd0;
      if (wb_req && wb_we_i) begin
        case (wb_adr_i)
          3'd0:    en      <= wb_dat_i[0];
          3'd1:    exp_len <= wb_dat_i[15:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wr_fec_dummy_pck_chk.sv
module tb_wr_fec_dummy_pck_chk;
  localparam int HDR = 7;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] snk_dat_i = '0;
  logic [1:0]  snk_adr_i = '0;
  logic [1:0]  snk_sel_i = 2'b11;
  logic        snk_cyc_i = 1'b0, snk_stb_i = 1'b0, snk_we_i = 1'b0;
  logic        snk_stall_o, snk_ack_o, snk_err_o;
  logic [2:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic        wb_ack_o, frame_ok_p_o;

  wr_fec_dummy_pck_chk dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .snk_dat_i(snk_dat_i), .snk_adr_i(snk_adr_i), .snk_sel_i(snk_sel_i),
    .snk_cyc_i(snk_cyc_i), .snk_stb_i(snk_stb_i), .snk_we_i(snk_we_i),
    .snk_stall_o(snk_stall_o), .snk_ack_o(snk_ack_o), .snk_err_o(snk_err_o),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_ack_o(wb_ack_o), .frame_ok_p_o(frame_ok_p_o)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int ack_seen = 0, stall_seen = 0, ok_seen = 0;

  always @(negedge clk_sys) begin
    if (snk_ack_o)    ack_seen++;
    if (snk_stall_o)  stall_seen++;
    if (frame_ok_p_o) ok_seen++;
  end

  // Reference model of the statistics block
  int          m_rx = 0, m_len = 0, m_pay = 0, m_seq = 0, m_ok = 0;
  logic [15:0] m_last = '0, m_exp_len = '0;
  logic        m_valid = 1'b0, m_en = 1'b0;

  logic [15:0] fw [0:299];
  int          fn;
  logic        fhi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [2:0] adr, input logic [31:0] wdat,
                         output logic [31:0] rdat);
    int g;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wdat;
    g = 0;
    do begin @(posedge clk_sys); #1; g++; end while (!wb_ack_o && g < 8);
    rdat = wb_dat_o;
    chk($sformatf("wb_ack_lat_a%0d", adr), 32'(g), 32'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  task automatic wb_write(input logic [2:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, d, dummy);
  endtask

  task automatic rd(input logic [2:0] adr, input string tag, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(1'b0, adr, 32'd0, r);
    chk(tag, r, exp);
  endtask

  task automatic push_beat(input logic [1:0] adr, input logic [15:0] dat, input logic [1:0] sel);
    logic st;
    int g;
    snk_stb_i = 1'b1; snk_we_i = 1'b1; snk_adr_i = adr; snk_dat_i = dat; snk_sel_i = sel;
    g = 0;
    do begin st = snk_stall_o; @(posedge clk_sys); #1; g++; end while (st && g < 4);
    if (st) chk("stall_bound", 32'(st), 32'd0);
  endtask

  task automatic drive_beats(input int first, input int last, input int oob_at);
    snk_cyc_i = 1'b1;
    for (int i = first; i < last; i++) begin
      if (i == oob_at) push_beat(2'd1, 16'($urandom), 2'b11);
      push_beat(2'd0, fw[i], (fhi && i == fn - 1) ? 2'b10 : 2'b11);
    end
    snk_stb_i = 1'b0; snk_we_i = 1'b0; snk_adr_i = 2'd0;
  endtask

  task automatic end_frame();
    snk_cyc_i = 1'b0; snk_stb_i = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  task automatic build_frame(input logic [15:0] sq, input int nbytes);
    logic [15:0] v;
    fn  = (nbytes + 1) / 2;
    fhi = (nbytes % 2) == 1;
    for (int i = 0; i < fn; i++) begin
      if (i < HDR)       v = 16'($urandom);
      else if (i == HDR) v = sq;
      else               v = sq + 16'(i - HDR);
      if (fhi && i == fn - 1) v[7:0] = 8'($urandom);
      fw[i] = v;
    end
  endtask

  task automatic model_clr();
    m_rx = 0; m_len = 0; m_pay = 0; m_seq = 0; m_last = '0; m_valid = 1'b0;
  endtask

  task automatic model_frame();
    int          len;
    logic        reached, pay, lerr, serr;
    logic [15:0] sq, ex;
    len     = 2 * fn - (fhi ? 1 : 0);
    reached = fn > HDR;
    sq      = reached ? fw[HDR] : 16'h0;
    pay     = 1'b0;
    for (int i = HDR + 1; i < fn; i++) begin
      ex = sq + 16'(i - HDR);
      if (fhi && i == fn - 1) begin
        if (fw[i][15:8] != ex[15:8]) pay = 1'b1;
      end else if (fw[i] != ex) pay = 1'b1;
    end
    lerr = !reached || (len != int'(m_exp_len));
    serr = reached && m_valid && (sq != m_last + 16'd1);
    if (m_en) begin
      m_rx++;
      if (lerr) m_len++;
      if (pay)  m_pay++;
      if (serr) m_seq++;
      if (reached) begin m_last = sq; m_valid = 1'b1; end
      if (!(lerr || pay || serr)) m_ok++;
    end
  endtask

  task automatic run_frame(input string tag, input logic [15:0] sq, input int nbytes,
                           input int oob_at, input int ck, input logic [15:0] cval);
    int a0, s0;
    build_frame(sq, nbytes);
    if (ck > 0 && HDR + ck < fn) fw[HDR + ck] = cval;
    a0 = ack_seen; s0 = stall_seen;
    drive_beats(0, fn, oob_at);
    end_frame();
    repeat (3) @(posedge clk_sys);
    #1;
    chk({tag, "_acks"}, 32'(ack_seen - a0), 32'(fn + ((oob_at >= 0 && oob_at < fn) ? 1 : 0)));
    chk({tag, "_stall"}, 32'(stall_seen - s0), 32'd1);
    model_frame();
  endtask

  task automatic check_regs(input string tag);
    rd(3'd0, {tag, "_ctrl"},    {31'd0, m_en});
    rd(3'd1, {tag, "_explen"},  {16'd0, m_exp_len});
    rd(3'd2, {tag, "_rx"},      32'(m_rx));
    rd(3'd3, {tag, "_lenerr"},  32'(m_len));
    rd(3'd4, {tag, "_payerr"},  32'(m_pay));
    rd(3'd5, {tag, "_seqerr"},  32'(m_seq));
    rd(3'd6, {tag, "_lastseq"}, {15'd0, m_valid, m_last});
    chk({tag, "_okpulses"}, 32'(ok_seen), 32'(m_ok));
  endtask

  initial begin
    logic [15:0] sq;
    int nb, pb, ck, oob, a0, s0;

    // Reset with both buses active: nothing may respond.
    snk_cyc_i = 1'b1; snk_stb_i = 1'b1; snk_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    repeat (4) @(posedge clk_sys);
    #1;
    chk("rst_snk_ack", 32'(snk_ack_o), 32'd0);
    chk("rst_stall", 32'(snk_stall_o), 32'd0);
    chk("rst_err", 32'(snk_err_o), 32'd0);
    chk("rst_wb_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_wb_dat", wb_dat_o, 32'd0);
    chk("rst_ok", 32'(frame_ok_p_o), 32'd0);
    snk_cyc_i = 1'b0; snk_stb_i = 1'b0; snk_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk_sys); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check_regs("rst");
    rd(3'd7, "adr7", 32'd0);

    // Ten clean frames, some with an out-of-band beat mixed in.
    wb_write(3'd1, 32'd500); m_exp_len = 16'd500;
    wb_write(3'd0, 32'd1);   m_en = 1'b1;
    for (int s = 0; s < 10; s++)
      run_frame("clean", 16'(s), 500, (s % 3 == 0) ? int'($urandom_range(0, 249)) : -1, 0, 16'h0);
    check_regs("clean10");

    // Sequence gap.
    wb_write(3'd0, 32'd3); model_clr();
    run_frame("seq3", 16'd3, 500, -1, 0, 16'h0);
    run_frame("seq5", 16'd5, 500, -1, 0, 16'h0);
    check_regs("seqgap");

    // Corrupted payload word 20.
    wb_write(3'd0, 32'd3); model_clr();
    run_frame("corrupt", 16'd0, 500, -1, 20, 16'hDEAD);
    check_regs("corrupt");

    // Odd length, then a frame cut short inside the header.
    wb_write(3'd0, 32'd3); model_clr();
    run_frame("odd", 16'd0, 499, -1, 0, 16'h0);
    check_regs("odd");
    run_frame("trunc", 16'h77, 8, -1, 0, 16'h0);
    check_regs("trunc");

    // Disabled: frames flow but statistics stay frozen.
    wb_write(3'd0, 32'd0); m_en = 1'b0;
    run_frame("dis", m_last + 16'd1, 500, 5, 0, 16'h0);
    check_regs("dis");
    wb_write(3'd0, 32'd1); m_en = 1'b1;

    // Randomized frames.
    for (int r = 0; r < 12; r++) begin
      sq  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : m_last + 16'd1;
      nb  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(6, 520)) : 500;
      pb  = (nb + 1) / 2 - HDR - 1;
      ck  = (pb > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, pb)) : 0;
      oob = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, (nb + 1) / 2)) : -1;
      run_frame("rand", sq, nb, oob, ck, 16'($urandom));
      if (r % 4 == 3) check_regs("rand");
    end

    // Clear in the DONE cycle while the next frame starts back to back.
    build_frame(m_last + 16'd7, 500);
    drive_beats(0, fn, -1);
    build_frame(16'h1234, 500);
    end_frame();
    a0 = ack_seen; s0 = stall_seen;
    model_clr();
    fork
      begin
        wb_write(3'd0, 32'd3);
        rd(3'd2, "b2b_rx_clr", 32'd0);
        rd(3'd3, "b2b_len_clr", 32'd0);
        rd(3'd4, "b2b_pay_clr", 32'd0);
        rd(3'd5, "b2b_seq_clr", 32'd0);
        rd(3'd6, "b2b_last_clr", 32'd0);
      end
      drive_beats(0, fn, -1);
    join
    end_frame();
    repeat (3) @(posedge clk_sys);
    #1;
    model_frame();
    chk("b2b_acks", 32'(ack_seen - a0), 32'(fn));
    chk("b2b_stall", 32'(stall_seen - s0), 32'd2);
    check_regs("b2b");

    // Reset in the middle of a payload, released with cyc still high.
    build_frame(m_last + 16'd1, 500);
    drive_beats(0, 100, -1);
    rst_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    chk("midrst_ack", 32'(snk_ack_o), 32'd0);
    chk("midrst_stall", 32'(snk_stall_o), 32'd0);
    s0 = stall_seen;
    rst_n = 1'b0;
    drive_beats(100, fn, -1);
    end_frame();
    repeat (3) @(posedge clk_sys);
    #1;
    chk("midrst_no_done", 32'(stall_seen - s0), 32'd0);
    m_en = 1'b0; m_exp_len = '0; model_clr();
    check_regs("midrst");
    wb_write(3'd1, 32'd500); m_exp_len = 16'd500;
    wb_write(3'd0, 32'd1);   m_en = 1'b1;
    run_frame("after_rst", 16'h42, 500, -1, 0, 16'h0);
    rd(3'd2, "after_rst_rx", 32'd1);
    check_regs("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
